// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write path: FSM states, default
// controller timings and the command codes that need the long settle time.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HI_E,
      ST_GAP,
      ST_LO_E,
      ST_WAIT
   } lcd_state_t;

   localparam int LCD_E_HIGH     = 12;
   localparam int LCD_NIBBLE_GAP = 50;
   localparam int LCD_CMD_WAIT   = 2000;
   localparam int LCD_LONG_WAIT  = 82000;

   localparam logic [7:0] LCD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_HOME  = 8'h02;

   // 0x03 is an alias of return-home on HD44780-style controllers.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && ((b == LCD_CLEAR) || (b == LCD_HOME) || (b == 8'h03));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer and
// moves the pointer one past the winner whenever the grant is taken.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            take,
   output logic [NREQ-1:0] gnt_oh,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_any
);

   logic [IDW-1:0] ptr;

   always_comb begin
      int idx;
      gnt_oh  = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!gnt_any && req[idx]) begin
            gnt_any     = 1'b1;
            gnt_id      = IDW'(idx);
            gnt_oh[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (take && gnt_any)
         ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
   end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Arbitrates byte writers onto the 4-bit LCD bus and serializes each byte
// as two enable-strobed nibbles followed by the controller settle time.
module lcd_write_scheduler
   import lcd_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int E_HIGH     = LCD_E_HIGH,
   parameter int NIBBLE_GAP = LCD_NIBBLE_GAP,
   parameter int CMD_WAIT   = LCD_CMD_WAIT,
   parameter int LONG_WAIT  = LCD_LONG_WAIT,
   parameter int CNT_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_rs,
   input  logic [8*NREQ-1:0] req_byte,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic              busy,
   output logic [3:0]        data,
   output logic              lcd_e,
   output logic              lcd_rs,
   output logic              lcd_rw,
   output logic              SF_CE0
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   lcd_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       byte_q, sel_byte;
   logic             rs_q, sel_rs;
   logic [IDW-1:0]   id_q;
   logic             ack_pend;
   logic             take;

   logic [NREQ-1:0]  arb_oh;
   logic [IDW-1:0]   arb_id;
   logic             arb_any;

   assign take   = (state == ST_IDLE) && init_done && arb_any;
   assign lcd_rw = 1'b0;
   assign SF_CE0 = 1'b1;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .take    (take),
      .gnt_oh  (arb_oh),
      .gnt_id  (arb_id),
      .gnt_any (arb_any)
   );

   always_comb begin
      sel_byte = '0;
      sel_rs   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_oh[i]) begin
            sel_byte = req_byte[8*i +: 8];
            sel_rs   = req_rs[i];
         end
      end
   end

   // One down-counter times every state; it is reloaded on entry and the
   // state advances on the cycle it reads 1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (take) begin
               state_nxt = ST_HI_E;
               cnt_nxt   = CNT_W'(E_HIGH);
            end
         end
         ST_HI_E: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_GAP;
               cnt_nxt   = CNT_W'(NIBBLE_GAP);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_LO_E;
               cnt_nxt   = CNT_W'(E_HIGH);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_LO_E: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = is_long_cmd(rs_q, byte_q) ? CNT_W'(LONG_WAIT) : CNT_W'(CMD_WAIT);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Pins are registered from the current state, so the bus lags the FSM by
   // one cycle; the extra ack_pend stage keeps ack aligned with the next gnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_q   <= '0;
         rs_q     <= 1'b0;
         id_q     <= '0;
         gnt      <= '0;
         ack      <= '0;
         ack_pend <= 1'b0;
         busy     <= 1'b0;
         lcd_e    <= 1'b0;
         lcd_rs   <= 1'b0;
         data     <= '0;
      end else begin
         if (take) begin
            byte_q <= sel_byte;
            rs_q   <= sel_rs;
            id_q   <= arb_id;
         end
         gnt      <= take ? arb_oh : '0;
         ack_pend <= (state == ST_WAIT) && (cnt == CNT_W'(1));
         ack      <= ack_pend ? (NREQ'(1) << id_q) : '0;
         busy     <= (state != ST_IDLE);
         lcd_e    <= (state == ST_HI_E) || (state == ST_LO_E);
         case (state)
            ST_HI_E, ST_GAP: begin
               data   <= byte_q[7:4];
               lcd_rs <= rs_q;
            end
            ST_LO_E, ST_WAIT: begin
               data   <= byte_q[3:0];
               lcd_rs <= rs_q;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed and randomized checks of lcd_write_scheduler against a
// transaction-level model of grant, strobe and settle timing.
module tb_lcd_write_scheduler;

   localparam int NREQ  = 2;
   localparam int EH    = 3;
   localparam int NG    = 5;
   localparam int CW    = 20;
   localparam int LW    = 60;
   localparam int CNT_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              init_done = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ-1:0]   req_rs = '0;
   logic [8*NREQ-1:0] req_byte = '0;
   logic [NREQ-1:0]   gnt, ack;
   logic              busy, lcd_e, lcd_rs, lcd_rw, SF_CE0;
   logic [3:0]        data;

   always #5 clk = ~clk;

   lcd_write_scheduler #(
      .NREQ       (NREQ),
      .E_HIGH     (EH),
      .NIBBLE_GAP (NG),
      .CMD_WAIT   (CW),
      .LONG_WAIT  (LW),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_done (init_done),
      .req       (req),
      .req_rs    (req_rs),
      .req_byte  (req_byte),
      .gnt       (gnt),
      .ack       (ack),
      .busy      (busy),
      .data      (data),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .SF_CE0    (SF_CE0)
   );

   typedef struct {
      int cyc;
      int id;
   } ack_t;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   bit         act = 0;
   int         t0 = 0;
   int         tlen = 0;
   int         ptr = 0;
   int         gnt_cyc = -1;
   int         gnt_id = 0;
   logic [7:0] mbyte = '0;
   logic       mrs = 1'b0;
   logic [3:0] exp_data = '0;
   logic       exp_rs = 1'b0;
   ack_t       ackq[$];
   int         remaining[NREQ];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, want);
      end
   endtask

   function automatic bit is_long(input logic rs, input logic [7:0] b);
      return !rs && (b >= 8'h01) && (b <= 8'h03);
   endfunction

   // Grant decision for the next cycle, from the inputs present at that edge.
   task automatic decide();
      int nxt;
      int pick;
      nxt  = cyc + 1;
      pick = -1;
      if (!rst && init_done && (req != '0) && (!act || (nxt - t0 >= tlen))) begin
         for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (ptr + i) % NREQ;
            if (pick < 0 && req[j]) pick = j;
         end
         act     = 1;
         t0      = nxt;
         mbyte   = req_byte[8*pick +: 8];
         mrs     = req_rs[pick];
         tlen    = 1 + 2*EH + NG + (is_long(mrs, mbyte) ? LW : CW);
         ackq.push_back('{t0 + tlen, pick});
         ptr     = (pick + 1) % NREQ;
         gnt_cyc = nxt;
         gnt_id  = pick;
      end
   endtask

   task automatic check();
      int k;
      logic [NREQ-1:0] eg, ea;
      logic ee, eb;
      k  = cyc - t0;
      eg = (gnt_cyc == cyc) ? (NREQ'(1) << gnt_id) : '0;
      ea = '0;
      if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
         ea = NREQ'(1) << ackq[0].id;
         void'(ackq.pop_front());
      end
      ee = 1'b0;
      eb = 1'b0;
      if (act) begin
         ee = (k >= 1 && k <= EH) || (k >= EH + NG + 1 && k <= 2*EH + NG);
         eb = (k >= 1 && k < tlen);
         if (k >= 1 && k <= EH + NG) exp_data = mbyte[7:4];
         else if (k > EH + NG && k < tlen) exp_data = mbyte[3:0];
         if (k >= 1 && k < tlen) exp_rs = mrs;
      end
      chk("gnt", 32'(gnt), 32'(eg));
      chk("ack", 32'(ack), 32'(ea));
      chk("lcd_e", 32'(lcd_e), 32'(ee));
      chk("busy", 32'(busy), 32'(eb));
      chk("data", 32'(data), 32'(exp_data));
      chk("lcd_rs", 32'(lcd_rs), 32'(exp_rs));
      chk("lcd_rw", 32'(lcd_rw), 32'd0);
      chk("sf_ce0", 32'(SF_CE0), 32'd1);
   endtask

   task automatic rand_cmd(output logic rs, output logic [7:0] b);
      if ($urandom_range(0, 3) == 0) begin
         rs = 1'b0;
         b  = 8'($urandom_range(1, 3));
      end else begin
         rs = 1'($urandom_range(0, 1));
         b  = 8'($urandom);
      end
   endtask

   task automatic set_req(input int i, input logic rs, input logic [7:0] b);
      req_rs[i]          = rs;
      req_byte[8*i +: 8] = b;
      req[i]             = 1'b1;
   endtask

   // A requester drops req once it sees its grant, or queues its next byte.
   task automatic tick();
      logic rs;
      logic [7:0] b;
      decide();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check();
      if (gnt_cyc == cyc) begin
         if (remaining[gnt_id] > 0) begin
            remaining[gnt_id]--;
            rs_gen: begin
               rand_cmd(rs, b);
               set_req(gnt_id, 1'b1, b);
            end
         end else begin
            req[gnt_id] = 1'b0;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic model_reset();
      act      = 0;
      ackq.delete();
      ptr      = 0;
      gnt_cyc  = -1;
      exp_data = '0;
      exp_rs   = 1'b0;
   endtask

   localparam int TORD  = 1 + 2*EH + NG + CW;
   localparam int TLONG = 1 + 2*EH + NG + LW;

   initial begin : stim
      logic rs;
      logic [7:0] b;
      int guard;
      for (int i = 0; i < NREQ; i++) remaining[i] = 0;

      // Reset state
      run(3);
      rst = 1'b0;
      run(2);

      // Single data write 0x49
      init_done = 1'b1;
      set_req(0, 1'b1, 8'h49);
      run(TORD + 4);

      // Two simultaneous pairs: second pair is served req1 first
      set_req(0, 1'b1, 8'($urandom));
      set_req(1, 1'b1, 8'($urandom));
      run(2*TORD + 4);
      set_req(0, 1'b1, 8'($urandom));
      set_req(1, 1'b0, 8'h38);
      run(2*TORD + 4);

      // Long and ordinary commands
      set_req(0, 1'b0, 8'h01);
      run(TLONG + 3);
      set_req(1, 1'b0, 8'h28);
      run(TORD + 3);
      set_req(0, 1'b0, 8'h03);
      run(TLONG + 3);
      set_req(1, 1'b1, 8'h02);
      run(TORD + 3);

      // Init gating
      init_done = 1'b0;
      set_req(1, 1'b1, 8'h5a);
      run(100);
      init_done = 1'b1;
      run(TORD + 3);

      // Reset during the low-nibble strobe
      set_req(0, 1'b1, 8'hc3);
      guard = 0;
      while (!(act && (cyc - t0 == EH + NG + 2)) && guard < 100) begin
         tick();
         guard++;
      end
      chk("reach_lo_e", 32'(guard < 100), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_lcd_e", 32'(lcd_e), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      model_reset();
      set_req(0, 1'b1, 8'h7e);
      set_req(1, 1'b1, 8'h81);
      run(3);
      rst = 1'b0;
      run(2*TORD + 4);

      // Back-to-back: three bytes from requester 0
      remaining[0] = 2;
      set_req(0, 1'b1, 8'h41);
      run(3*TORD + 4);

      // Random traffic with withdrawals and init_done toggling
      for (int n = 0; n < 900; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 9) == 0) begin
               rand_cmd(rs, b);
               set_req(i, rs, b);
            end else if (req[i] && $urandom_range(0, 59) == 0) begin
               req[i] = 1'b0;
            end
         end
         if ($urandom_range(0, 79) == 0) init_done = ~init_done;
         tick();
      end
      init_done = 1'b1;
      req = '0;
      run(TLONG + 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

endmodule
